// File: rtl/my_pkg.sv
// Shared AST alert types: request/ack bundles and the ack sequencer state.
package my_pkg;

  localparam int AstNumAlerts = 2;

  typedef struct packed {
    logic p;
    logic n;
  } ast_dif_t;

  typedef struct packed {
    ast_dif_t [AstNumAlerts-1:0] alerts;
  } ast_alert_req_t;

  typedef struct packed {
    ast_dif_t [AstNumAlerts-1:0] alerts_ack;
  } ast_alert_rsp_t;

  typedef enum logic {
    AckIdle,
    AckActive
  } ast_ack_state_e;

endpackage

// File: rtl/ast_alert_rr_arb.sv
// Combinational round-robin arbiter: first eligible index after `last`.
module ast_alert_rr_arb #(
  parameter int NumReq = 2,
  parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] eligible,
  input  logic [IdxW-1:0]   last,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   gnt_idx
);

  logic            found;
  logic [IdxW-1:0] idx;
  int              j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    j       = 0;
    for (int k = 1; k <= NumReq; k++) begin
      j   = (int'(last) + k) % NumReq;
      idx = IdxW'(j);
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt[gnt_idx] = found;
  end

endmodule

// File: rtl/ast_alert_ack_ctrl.sv
// Round-robin four-phase acknowledger for AST alerts with timeout lockout.
module ast_alert_ack_ctrl
  import my_pkg::*;
#(
  parameter int TimeoutCycles = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  ast_alert_req_t          alert_req_i,
  output ast_alert_rsp_t          alert_rsp_o,
  output logic [AstNumAlerts-1:0] alert_event_o,
  output logic [AstNumAlerts-1:0] alert_timeout_o,
  output logic                    busy_o
);

  localparam int N    = AstNumAlerts;
  localparam int IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int CntW = $clog2(TimeoutCycles);

  ast_ack_state_e  state_q, state_d;
  logic [N-1:0]    req, elig, gnt;
  logic [N-1:0]    ack_q, ack_d;
  logic [N-1:0]    evt_q, evt_d;
  logic [N-1:0]    tmo_q, tmo_d;
  logic [N-1:0]    stuck_q, stuck_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] gnt_idx;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    unused_n;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i]      = alert_req_i.alerts[i].p;
      unused_n[i] = alert_req_i.alerts[i].n;
    end
  end

  assign elig = req & ~stuck_q;

  ast_alert_rr_arb #(
    .NumReq(N),
    .IdxW  (IdxW)
  ) u_arb (
    .eligible(elig),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    evt_d   = '0;
    tmo_d   = '0;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    stuck_d = stuck_q & req;
    unique case (state_q)
      AckIdle: begin
        if (|elig) begin
          ack_d   = gnt;
          sel_d   = gnt_idx;
          last_d  = gnt_idx;
          cnt_d   = '0;
          state_d = AckActive;
        end
      end
      AckActive: begin
        cnt_d = cnt_q + 1'b1;
        // A dropped request takes priority over the deadline.
        if (!req[sel_q]) begin
          ack_d        = '0;
          evt_d[sel_q] = 1'b1;
          state_d      = AckIdle;
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          ack_d          = '0;
          tmo_d[sel_q]   = 1'b1;
          stuck_d[sel_q] = 1'b1;
          state_d        = AckIdle;
        end
      end
      default: state_d = AckIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= AckIdle;
      ack_q   <= '0;
      evt_q   <= '0;
      tmo_q   <= '0;
      stuck_q <= '0;
      sel_q   <= '0;
      last_q  <= IdxW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      evt_q   <= evt_d;
      tmo_q   <= tmo_d;
      stuck_q <= stuck_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      alert_rsp_o.alerts_ack[i].p = ack_q[i];
      alert_rsp_o.alerts_ack[i].n = ~ack_q[i];
    end
  end

  assign alert_event_o   = evt_q;
  assign alert_timeout_o = tmo_q;
  assign busy_o          = (state_q == AckActive);

endmodule
